// File: rtl/trap_controller_if.sv
// -----------------------------------------------------------------------------
// trap_if
// Bundle of everything the trap controller exchanges with the pipeline, the
// CSR file and the fetch unit. Clock and reset are kept outside the bundle.
//
//   master modport : the pipeline/CSR side, which drives the exception, interrupt,
//                    CSR and flush-ack inputs and observes the trap results
//   slave modport  : the trap controller itself
//
// Inputs to the controller:
//   exc_valid_i / exc_cause_i / exc_pc_i / exc_tval_i  per-source exceptions
//                                                      (index NUM_SRC-1 = oldest)
//   irq_pending_i / irq_enable_i / mstatus_mie_i       mip, mie, mstatus.MIE
//   irq_pc_i       mepc to use when an interrupt is taken
//   mtvec_i        trap vector base and mode
//   flush_ack_i    pipeline has drained
// Outputs from the controller:
//   busy_o, flush_req_o, redirect_valid_o,
//   trap_vector_o, mcause_o, mepc_o, mtval_o
// -----------------------------------------------------------------------------
interface trap_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int NUM_IRQ = 16
);
    logic [NUM_SRC-1:0]           exc_valid_i;
    logic [NUM_SRC-1:0][4:0]      exc_cause_i;
    logic [NUM_SRC-1:0][XLEN-1:0] exc_pc_i;
    logic [NUM_SRC-1:0][XLEN-1:0] exc_tval_i;
    logic [NUM_IRQ-1:0]           irq_pending_i;
    logic [NUM_IRQ-1:0]           irq_enable_i;
    logic                         mstatus_mie_i;
    logic [XLEN-1:0]              irq_pc_i;
    logic [XLEN-1:0]              mtvec_i;
    logic                         flush_ack_i;

    logic                         busy_o;
    logic                         flush_req_o;
    logic                         redirect_valid_o;
    logic [XLEN-1:0]              trap_vector_o;
    logic [XLEN-1:0]              mcause_o;
    logic [XLEN-1:0]              mepc_o;
    logic [XLEN-1:0]              mtval_o;

    modport master (
        output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
        output irq_pending_i, irq_enable_i, mstatus_mie_i, irq_pc_i,
        output mtvec_i, flush_ack_i,
        input  busy_o, flush_req_o, redirect_valid_o,
        input  trap_vector_o, mcause_o, mepc_o, mtval_o
    );

    modport slave (
        input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
        input  irq_pending_i, irq_enable_i, mstatus_mie_i, irq_pc_i,
        input  mtvec_i, flush_ack_i,
        output busy_o, flush_req_o, redirect_valid_o,
        output trap_vector_o, mcause_o, mepc_o, mtval_o
    );
endinterface

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
// Sequential trap controller for the RV32IM core. It arbitrates the pipeline
// exception sources and the machine interrupt lines, then captures the winning
// trap. Next it holds a flush request until the pipeline acknowledges, and
// finally issues a one-cycle redirect. That redirect carries the trap vector
// and the mcause/mepc/mtval values for the CSR file.
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    trap_if.slave (see trap_controller_if.sv for the signal list)
//
// Every output comes from a register or from the state register, so there is
// no combinational path from the inputs to the outputs.
// -----------------------------------------------------------------------------
module trap_controller #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int NUM_IRQ = 16
) (
    input  logic  clk_i,
    input  logic  rst_i,
    trap_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cause_q, cause_d;
    logic            intr_q, intr_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] vector_q, vector_d;

    logic            busy, flush_req, redirect_valid;

    // An interrupt line counts only when it is pending, enabled and globally
    // unmasked.
    logic [NUM_IRQ-1:0] irq_active;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_irq_active
            assign irq_active[gi] = bus.irq_pending_i[gi] & bus.irq_enable_i[gi]
                                  & bus.mstatus_mie_i;
        end
    endgenerate

    // Arbitration. The ascending loops let the highest index win. The
    // exception loop runs after the interrupt loop, so any valid exception
    // overrides an interrupt.
    logic            sel_valid, sel_intr;
    logic [4:0]      sel_cause;
    logic [XLEN-1:0] sel_pc, sel_tval, sel_vector, mtvec_base;

    always_comb begin
        sel_valid = 1'b0;
        sel_intr  = 1'b0;
        sel_cause = '0;
        sel_pc    = '0;
        sel_tval  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_active[i]) begin
                sel_valid = 1'b1;
                sel_intr  = 1'b1;
                sel_cause = 5'(i);
                sel_pc    = bus.irq_pc_i;
                sel_tval  = '0;
            end
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            if (bus.exc_valid_i[s]) begin
                sel_valid = 1'b1;
                sel_intr  = 1'b0;
                sel_cause = bus.exc_cause_i[s];
                sel_pc    = bus.exc_pc_i[s];
                sel_tval  = bus.exc_tval_i[s];
            end
        end
    end

    // Only mode 01 combined with an interrupt offsets the base. The reserved
    // modes fall back to direct. The sum wraps naturally at XLEN bits.
    assign mtvec_base = {bus.mtvec_i[XLEN-1:2], 2'b00};
    assign sel_vector = (sel_intr && (bus.mtvec_i[1:0] == 2'b01))
                      ? mtvec_base + {{(XLEN-7){1'b0}}, sel_cause, 2'b00}
                      : mtvec_base;

    // Next state, capture and state-decoded outputs.
    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        intr_d         = intr_q;
        epc_d          = epc_q;
        tval_d         = tval_q;
        vector_d       = vector_q;
        busy           = (state_q != ST_IDLE);
        flush_req      = (state_q == ST_FLUSH);
        redirect_valid = (state_q == ST_REDIRECT);

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    cause_d  = sel_cause;
                    intr_d   = sel_intr;
                    epc_d    = sel_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
                    tval_d   = sel_tval;
                    vector_d = sel_vector;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (bus.flush_ack_i) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            intr_q   <= 1'b0;
            epc_q    <= '0;
            tval_q   <= '0;
            vector_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            intr_q   <= intr_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            vector_q <= vector_d;
        end
    end

    assign bus.busy_o           = busy;
    assign bus.flush_req_o      = flush_req;
    assign bus.redirect_valid_o = redirect_valid;
    assign bus.trap_vector_o    = vector_q;
    assign bus.mcause_o         = {intr_q, {(XLEN-6){1'b0}}, cause_q};
    assign bus.mepc_o           = epc_q;
    assign bus.mtval_o          = tval_q;
endmodule

// File: doc/trap_controller.md
# trap_controller

Parametrised, sequential trap controller for the RV32IM core. It arbitrates `NUM_SRC` pipeline exception sources and `NUM_IRQ` machine-level interrupt lines, and captures the winning trap into registers. It then runs a flush handshake with the pipeline and issues a single-cycle redirect carrying the trap vector and CSR update values (mcause/mepc/mtval). It sits between the pipeline stages and the CSR file / fetch unit, and replaces the earlier purely combinational handler.

## Interface
- `XLEN`, 32, data/address width
- `NUM_SRC`, 4, exception sources; index `NUM_SRC-1` is the oldest instruction (writeback), index 0 the youngest (fetch)
- `NUM_IRQ`, 16, interrupt lines; line i has cause code i (3=MSI, 7=MTI, 11=MEI, 16+ platform)
- `clk_i` in 1 — single clock, all state on rising edge
- `rst_i` in 1 — asynchronous, active-high reset
- `exc_valid_i` in NUM_SRC — per-source exception valid
- `exc_cause_i` in NUM_SRC×5 — per-source exception cause code
- `exc_pc_i` in NUM_SRC×XLEN — per-source faulting PC
- `exc_tval_i` in NUM_SRC×XLEN — per-source trap value
- `irq_pending_i` in NUM_IRQ — mip bits, level-sensitive
- `irq_enable_i` in NUM_IRQ — mie bits
- `mstatus_mie_i` in 1 — global machine interrupt enable
- `irq_pc_i` in XLEN — PC of the oldest un-retired instruction (mepc for interrupts)
- `mtvec_i` in XLEN — mtvec; [1:0] is mode, [XLEN-1:2] is base
- `flush_ack_i` in 1 — pipeline reports it has drained/killed
- `busy_o` out 1 — state ≠ IDLE
- `flush_req_o` out 1 — request pipeline flush
- `redirect_valid_o` out 1 — one-cycle fetch redirect pulse; also the CSR trap write-enable
- `trap_vector_o` out XLEN — redirect target
- `mcause_o` out XLEN — bit XLEN-1 = interrupt, [4:0] = cause, other bits 0
- `mepc_o` out XLEN — captured PC, bits [1:0] forced to 0
- `mtval_o` out XLEN — captured tval (0 for interrupts)

## Operation
- FSM states: IDLE → FLUSH → REDIRECT → IDLE.
- **IDLE:**
  - Evaluate arbitration every cycle. If a trap is selected, register cause, epc, tval and interrupt flag, then go to FLUSH.
- **Arbitration:**
  - Any `exc_valid_i` set: the highest-index valid source wins; its cause, pc and tval are captured.
  - Exceptions always beat interrupts.
  - Otherwise, if `mstatus_mie_i` is set and `irq_pending_i & irq_enable_i` is nonzero, the highest set index wins. The interrupt flag is set, epc = `irq_pc_i`, and tval = 0.
- **FLUSH:**
  - `flush_req_o` = 1 throughout.
  - Stay in FLUSH until `flush_ack_i` is 1, then go to REDIRECT.
  - Inputs are ignored in this state; captured values do not change.
- **REDIRECT:**
  - `redirect_valid_o` = 1 for exactly one cycle, then IDLE.
  - `flush_req_o` = 0.
- **Trap vector:**
  - base = {mtvec_i[XLEN-1:2], 2'b00}.
  - mode 01 with the interrupt flag set: base + (cause << 2).
  - Exceptions, and modes 00/10/11: base. Reserved modes behave as direct.
  - The addition wraps modulo 2^XLEN.
- **Output hold:** `trap_vector_o`, `mcause_o`, `mepc_o` and `mtval_o` come from registers. They are valid from FLUSH onward and hold until the next capture.
- **Simultaneous events:**
  - An exception and an interrupt in the same IDLE cycle: the exception is taken. The interrupt stays pending and is re-evaluated on return to IDLE.
- **While busy:** new exceptions and interrupts are not latched.
- **Reset:** state = IDLE; all outputs = 0, including `busy_o`. Reset asserted mid-FLUSH or mid-REDIRECT aborts with no redirect pulse.

## Timing
- Arbitration selects in cycle N (IDLE). In cycle N+1, `flush_req_o` = 1, `busy_o` = 1 and the captured outputs are valid.
- If `flush_ack_i` is first seen high in cycle M (M ≥ N+1), then `redirect_valid_o` = 1 in M+1, and the FSM is in IDLE at M+2. The earliest next trap selection is M+2.
- Minimum trap latency with immediate ack: redirect in N+2.
- `flush_ack_i` outside FLUSH is ignored.
- No combinational path from inputs to outputs.

## Test plan
- **Single exception:** source 2, cause 5, pc 0x100, tval 0xDEAD; ack on the first FLUSH cycle → redirect in N+2. Expect mcause = 0x5, mepc = 0x100, mtval = 0xDEAD, vector = mtvec base.
- **Age priority:** sources 0 (cause 2) and 3 (cause 13) valid together → mcause = 13, mepc = exc_pc_i[3].
- **Vectored interrupt:** mtvec = 0x8000_0001, MIE = 1, irq 7 pending and enabled → mcause = 0x8000_0007, vector = 0x8000_001C, mtval = 0. With mtvec mode 00, vector = 0x8000_0000.
- **Exception vs interrupt:** exception (cause 2, pc 0x200) and irq 11 in the same cycle → exception taken. Irq 11 is taken on the next IDLE cycle, with mcause = 0x8000_000B.
- **Masking and hold-off:**
  - MIE = 0 with irq 3 pending → no `busy_o`.
  - `flush_ack_i` held low for 10 cycles → `flush_req_o` high for all 10 and no redirect. New exceptions during that window are ignored.
- **Reset mid-FLUSH:** assert `rst_i` in FLUSH → all outputs 0 asynchronously, no `redirect_valid_o` pulse, and the FSM in IDLE after release.
